frame_wr_ctrl: RTL and testbench

FRAME_WR_CTRL -- requirements
Module: frame_wr_ctrl

---
 rtl/frame_wr_ctrl.sv | 139 +++++++++++++
 tb/tb_frame_wr_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_wr_ctrl.sv
// Frame writer: cuts each video frame into bursts aimed at the frame-buffer bank
// captured at vsync, restarting cleanly whenever a new vsync arrives.
module frame_wr_ctrl #(
    parameter int FRAME_LEN  = 307200,
    parameter int BURST_LEN  = 64,
    parameter int BANK_SHIFT = 22,
    parameter int ADDR_W     = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vin_vs,
    input  logic [1:0]        wr_bank,
    input  logic [10:0]       fifo_usedw,
    output logic              fifo_flush,
    output logic              wr_burst_req,
    output logic [9:0]        wr_burst_len,
    output logic [ADDR_W-1:0] wr_burst_addr,
    input  logic              wr_burst_ack,
    input  logic              wr_burst_done,
    output logic              frame_done,
    output logic              busy
);
    localparam int OFF_W = $clog2(FRAME_LEN + 1);
    localparam int SUM_W = ((BANK_SHIFT + 2 > OFF_W) ? BANK_SHIFT + 2 : OFF_W) + 1;

    typedef enum logic [2:0] {IDLE, WAIT_DATA, REQ, BURST, UPDATE} state_t;

    state_t            state, state_next;
    logic              vs_d0, vs_d1, vs_d2;
    logic              start_evt;
    logic [1:0]        cur_bank;
    logic [OFF_W-1:0]  offset, rem, offset_sum;
    logic              pend_start;
    logic [9:0]        len, len_q;
    logic [SUM_W-1:0]  addr_full;
    logic [ADDR_W-1:0] addr_q;
    logic              restart, load_burst, set_pend, advance;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d0 <= 1'b0;
            vs_d1 <= 1'b0;
            vs_d2 <= 1'b0;
        end else begin
            vs_d0 <= vin_vs;
            vs_d1 <= vs_d0;
            vs_d2 <= vs_d1;
        end
    end

    assign start_evt  = vs_d1 & ~vs_d2;
    assign rem        = OFF_W'(FRAME_LEN) - offset;
    assign len        = (int'(rem) < BURST_LEN) ? 10'(rem) : 10'(BURST_LEN);
    assign offset_sum = offset + OFF_W'(len_q);
    assign addr_full  = (SUM_W'(cur_bank) << BANK_SHIFT) + SUM_W'(offset);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        restart    = 1'b0;
        load_burst = 1'b0;
        set_pend   = 1'b0;
        advance    = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (start_evt) restart = 1'b1;
            end
            WAIT_DATA: begin
                if (start_evt) begin
                    restart = 1'b1;
                end else if (rem != '0 && fifo_usedw >= 11'(len)) begin
                    load_burst = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                set_pend = start_evt;
                if (wr_burst_ack) state_next = BURST;
            end
            BURST: begin
                set_pend = start_evt;
                if (wr_burst_done) state_next = UPDATE;
            end
            UPDATE: begin
                advance = 1'b1;
                // A vsync during the transfer, or in this very cycle, wins over frame completion.
                if (pend_start || start_evt) begin
                    restart = 1'b1;
                end else if (offset_sum == OFF_W'(FRAME_LEN)) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = WAIT_DATA;
                end
            end
            default: state_next = IDLE;
        endcase
        if (restart) state_next = WAIT_DATA;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_bank   <= '0;
            offset     <= '0;
            pend_start <= 1'b0;
            len_q      <= '0;
            addr_q     <= '0;
        end else begin
            if (restart) begin
                cur_bank <= wr_bank;
                offset   <= '0;
            end else if (advance) begin
                offset <= offset_sum;
            end

            if (restart)       pend_start <= 1'b0;
            else if (set_pend) pend_start <= 1'b1;

            if (load_burst) begin
                len_q  <= len;
                addr_q <= ADDR_W'(addr_full);
            end
        end
    end

    assign fifo_flush    = restart;
    assign wr_burst_req  = (state == REQ);
    assign wr_burst_len  = len_q;
    assign wr_burst_addr = addr_q;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_frame_wr_ctrl.sv
// Bench for frame_wr_ctrl: a burst-level frame model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_frame_wr_ctrl;
    localparam int FRAME_LEN        = 200;
    localparam int BURST_LEN        = 64;
    localparam int BANK_SHIFT       = 22;
    localparam int ADDR_W           = 28;
    localparam int BURSTS_PER_FRAME = (FRAME_LEN + BURST_LEN - 1) / BURST_LEN;

    logic              clk           = 1'b0;
    logic              rst_n         = 1'b1;
    logic              vin_vs        = 1'b0;
    logic [1:0]        wr_bank       = 2'd0;
    logic [10:0]       fifo_usedw    = 11'd0;
    logic              wr_burst_ack  = 1'b0;
    logic              wr_burst_done = 1'b0;
    logic              fifo_flush;
    logic              wr_burst_req;
    logic [9:0]        wr_burst_len;
    logic [ADDR_W-1:0] wr_burst_addr;
    logic              frame_done;
    logic              busy;

    frame_wr_ctrl #(
        .FRAME_LEN (FRAME_LEN),
        .BURST_LEN (BURST_LEN),
        .BANK_SHIFT(BANK_SHIFT),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vin_vs       (vin_vs),
        .wr_bank      (wr_bank),
        .fifo_usedw   (fifo_usedw),
        .fifo_flush   (fifo_flush),
        .wr_burst_req (wr_burst_req),
        .wr_burst_len (wr_burst_len),
        .wr_burst_addr(wr_burst_addr),
        .wr_burst_ack (wr_burst_ack),
        .wr_burst_done(wr_burst_done),
        .frame_done   (frame_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Memory-side responder: ack and done after configurable delays.
    int   ack_delay  = 2;
    int   done_delay = 2;
    logic resp_en    = 1'b0;

    initial forever begin
        @(negedge clk);
        if (resp_en && rst_n && wr_burst_req) begin
            repeat (ack_delay) @(posedge clk);
            #1 wr_burst_ack = 1'b1;
            @(posedge clk);
            #1 wr_burst_ack = 1'b0;
            repeat (done_delay) @(posedge clk);
            #1 wr_burst_done = 1'b1;
            @(posedge clk);
            #1 wr_burst_done = 1'b0;
        end
    end

    // Frame model: burst k of a frame covers words [k*BURST_LEN, ...) of the bank.
    function automatic int exp_len(input int idx);
        int remaining;
        remaining = FRAME_LEN - idx * BURST_LEN;
        return (remaining < BURST_LEN) ? remaining : BURST_LEN;
    endfunction

    function automatic logic [31:0] exp_addr(input logic [1:0] bank, input int idx);
        return (32'(bank) << BANK_SHIFT) + 32'(idx * BURST_LEN);
    endfunction

    logic [1:0]        m_bank    = 2'd0;
    int                m_idx     = 0;
    int                m_done    = 0;
    logic              m_out     = 1'b0;
    logic              m_active  = 1'b0;
    logic              prev_req  = 1'b0;
    logic [9:0]        prev_len  = '0;
    logic [ADDR_W-1:0] prev_addr = '0;
    int                rise_cnt  = 0;
    int                flush_cnt = 0;
    int                fd_cnt    = 0;
    int                req_run   = 0;
    int                cap_len[$];
    logic [31:0]       cap_addr[$];

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            check("reset_outputs",
                  {26'd0, fifo_flush, wr_burst_req, frame_done, busy, |wr_burst_len, |wr_burst_addr},
                  32'd0);
            m_out    = 1'b0;
            m_active = 1'b0;
            m_idx    = 0;
            m_done   = 0;
            prev_req = 1'b0;
            req_run  = 0;
        end else begin
            check("busy", 32'(busy), 32'(m_active));
            if (fifo_flush) begin
                flush_cnt++;
                check("flush_vs_frame_done", 32'(frame_done), 32'd0);
                check("flush_no_outstanding", 32'(m_out), 32'd0);
                m_bank = wr_bank;
                m_idx  = 0;
                m_done = 0;
            end
            if (wr_burst_req) begin
                if (!prev_req) begin
                    rise_cnt++;
                    cap_len.push_back(int'(wr_burst_len));
                    cap_addr.push_back(32'(wr_burst_addr));
                    check("req_single_outstanding", 32'(m_out), 32'd0);
                    check("req_within_frame", 32'(m_idx < BURSTS_PER_FRAME), 32'd1);
                    check("req_len", 32'(wr_burst_len), exp_len(m_idx));
                    check("req_addr", 32'(wr_burst_addr), exp_addr(m_bank, m_idx));
                    req_run = 1;
                end else begin
                    check("req_len_stable", 32'(wr_burst_len), 32'(prev_len));
                    check("req_addr_stable", 32'(wr_burst_addr), 32'(prev_addr));
                    req_run++;
                end
                prev_len  = wr_burst_len;
                prev_addr = wr_burst_addr;
                if (wr_burst_ack) begin
                    m_out = 1'b1;
                    m_idx++;
                end
            end
            if (wr_burst_done && m_out) begin
                m_out = 1'b0;
                m_done++;
            end
            if (frame_done) begin
                fd_cnt++;
                check("frame_done_bursts", m_done, BURSTS_PER_FRAME);
            end
            prev_req = wr_burst_req;
            if (frame_done) m_active = 1'b0;
            if (fifo_flush) m_active = 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_vs();
        vin_vs = 1'b1;
        tick(4);
        vin_vs = 1'b0;
    endtask

    task automatic wait_rise(input int target, input string name);
        int n = 0;
        while (rise_cnt < target && n < 400) begin
            tick(1);
            n++;
        end
        check(name, 32'(rise_cnt >= target), 32'd1);
    endtask

    task automatic wait_fd(input int target, input string name);
        int n = 0;
        while (fd_cnt < target && n < 600) begin
            tick(1);
            n++;
        end
        check(name, 32'(fd_cnt >= target), 32'd1);
    endtask

    task automatic wait_req_low(input string name);
        int n = 0;
        while (wr_burst_req && n < 400) begin
            tick(1);
            n++;
        end
        check(name, 32'(wr_burst_req), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flush"}, 32'(fifo_flush), 32'd0);
        check({tag, "_req"}, 32'(wr_burst_req), 32'd0);
        check({tag, "_len"}, 32'(wr_burst_len), 32'd0);
        check({tag, "_addr"}, 32'(wr_burst_addr), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    int          nom_len[4]  = '{64, 64, 64, 8};
    logic [31:0] nom_addr[4] = '{32'h0080_0000, 32'h0080_0040, 32'h0080_0080, 32'h0080_00C0};

    initial begin
        int base_r, base_f, base_fd, base_c;

        #1 rst_n = 1'b0;
        #1 check_all_zero("por");
        tick(3);
        rst_n = 1'b1;
        tick(2);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_no_flush", flush_cnt, 32'd0);

        // Nominal frame into bank 2.
        wr_bank    = 2'd2;
        fifo_usedw = 11'd2047;
        resp_en    = 1'b1;
        pulse_vs();
        wait_fd(1, "nominal_frame_done");
        tick(3);
        check("nominal_busy_after", 32'(busy), 32'd0);
        check("nominal_fd_pulses", fd_cnt, 32'd1);
        check("nominal_bursts", cap_len.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < cap_len.size()) begin
                check("nominal_len", cap_len[i], nom_len[i]);
                check("nominal_addr", cap_addr[i], nom_addr[i]);
            end
        end

        // Starvation, then short tail, bank 1.
        wr_bank    = 2'd1;
        fifo_usedw = 11'd63;
        base_r     = rise_cnt;
        base_f     = flush_cnt;
        pulse_vs();
        check("starve_flush", flush_cnt, base_f + 1);
        check("starve_busy", 32'(busy), 32'd1);
        tick(50);
        check("starve_no_req", rise_cnt, base_r);
        check("starve_req_low", 32'(wr_burst_req), 32'd0);
        fifo_usedw = 11'd64;
        tick(1);
        check("starve_req_next", 32'(wr_burst_req), 32'd1);
        check("starve_len", 32'(wr_burst_len), 32'd64);
        check("starve_addr", 32'(wr_burst_addr), 32'h0040_0000);
        wait_rise(base_r + 3, "tail_third_req");
        fifo_usedw = 11'd7;
        tick(40);
        check("tail_no_req", rise_cnt, base_r + 3);
        check("tail_busy", 32'(busy), 32'd1);
        check("tail_no_fd", fd_cnt, 32'd1);
        fifo_usedw = 11'd8;
        tick(1);
        check("tail_req", 32'(wr_burst_req), 32'd1);
        check("tail_len", 32'(wr_burst_len), 32'd8);
        check("tail_addr", 32'(wr_burst_addr), 32'h0040_00C0);
        wait_fd(2, "tail_frame_done");
        tick(2);

        // Vsync during the second burst; the restarted request is then held for 20+ cycles.
        wr_bank    = 2'd2;
        fifo_usedw = 11'd2047;
        base_r     = rise_cnt;
        pulse_vs();
        wait_rise(base_r + 2, "mid_second_req");
        done_delay = 6;
        wait_req_low("mid_second_ack");
        base_f    = flush_cnt;
        base_fd   = fd_cnt;
        base_c    = cap_len.size();
        wr_bank   = 2'd3;
        ack_delay = 21;
        vin_vs    = 1'b1;
        wait_rise(base_r + 3, "mid_restart_req");
        vin_vs = 1'b0;
        check("mid_flush_once", flush_cnt, base_f + 1);
        check("mid_no_frame_done", fd_cnt, base_fd);
        if (cap_len.size() > base_c) begin
            check("mid_restart_len", cap_len[base_c], 32'd64);
            check("mid_restart_addr", cap_addr[base_c], 32'h00C0_0000);
        end
        wait_req_low("hold_ack");
        check("hold_run_20", 32'(req_run >= 20), 32'd1);

        // Reset while that burst is in flight.
        tick(2);
        check("pre_reset_busy", 32'(busy), 32'd1);
        base_r = rise_cnt;
        base_f = flush_cnt;
        rst_n  = 1'b0;
        #1 check_all_zero("midrst");
        ack_delay  = 2;
        done_delay = 2;
        tick(3);
        rst_n = 1'b1;
        tick(30);
        check("post_reset_no_req", rise_cnt, base_r);
        check("post_reset_no_flush", flush_cnt, base_f);
        check("post_reset_busy", 32'(busy), 32'd0);
        wr_bank = 2'd1;
        base_c  = cap_len.size();
        base_fd = fd_cnt;
        pulse_vs();
        wait_fd(base_fd + 1, "post_reset_frame_done");
        check("post_reset_bursts", cap_len.size() - base_c, 32'd4);
        if (cap_len.size() > base_c) begin
            check("post_reset_len", cap_len[base_c], 32'd64);
            check("post_reset_addr", cap_addr[base_c], 32'h0040_0000);
        end

        // vin_vs already high when reset releases: exactly one start.
        rst_n  = 1'b0;
        vin_vs = 1'b1;
        tick(2);
        base_f  = flush_cnt;
        base_fd = fd_cnt;
        rst_n   = 1'b1;
        tick(10);
        check("vs_high_release_flush", flush_cnt, base_f + 1);
        wait_fd(base_fd + 1, "vs_high_frame_done");
        tick(20);
        check("vs_high_single_start", flush_cnt, base_f + 1);
        vin_vs = 1'b0;
        tick(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
